// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - multiplexed 7-segment scan driver with blanking gap
//
// Purpose: synchronises the divided scan clock, and on each rising edge steps
// through N_DIGITS digit slots. Every slot opens with BLANK_CYCLES cycles of
// all anodes off, then lights the slot's anode. The slot's digit value, decimal
// point and mask bit are captured when the slot begins.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   scan_clk   divided scan clock, asynchronous to clk
//   en         display enable; low forces IDLE and restarts at digit 0
//   digits     4-bit hex value per digit, digit i at [4i+3:4i]
//   dp         decimal point per digit, active-high
//   blank_mask 1 = digit i is never lit
//   an         anode enables, active-low, at most one low
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp_n       decimal point, active-low
//   digit_idx  index of the current slot
//   frame_done one-cycle pulse when the scan wraps from the last digit to 0

module display_scan_mux #(
  parameter int N_DIGITS     = 4,
  parameter int BLANK_CYCLES = 16,
  parameter int IDX_W        = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_clk,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank_mask,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DIGITS - 1);
  localparam logic [7:0]       LAST_BLNK = 8'(BLANK_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  sync1, sync2, sync3;
  logic                  scan_tick;
  logic [7:0]            cnt_q, cnt_d;
  logic                  mask_q, mask_d;
  logic [IDX_W-1:0]      idx_d, nidx;
  logic [N_DIGITS-1:0]   an_d;
  logic [6:0]            seg_d;
  logic                  dpn_d, fd_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // sync3 only delays sync2 so a rising edge yields a single-cycle tick.
  assign scan_tick = sync2 & ~sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      mask_q     <= 1'b0;
      digit_idx  <= '0;
      an         <= '1;
      seg        <= 7'h7F;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      sync1      <= scan_clk;
      sync2      <= sync1;
      sync3      <= sync2;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      digit_idx  <= idx_d;
      an         <= an_d;
      seg        <= seg_d;
      dp_n       <= dpn_d;
      frame_done <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    idx_d   = digit_idx;
    an_d    = an;
    seg_d   = seg;
    dpn_d   = dp_n;
    fd_d    = 1'b0;
    nidx    = (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      mask_d  = 1'b0;
      idx_d   = '0;
      an_d    = '1;
      seg_d   = 7'h7F;
      dpn_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // Slot 0 is captured here so seg settles while anodes are still off.
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
          an_d    = '1;
          seg_d   = hex7(digits[3:0]);
          dpn_d   = ~dp[0];
          mask_d  = blank_mask[0];
        end
        BLANK: begin
          an_d = '1;
          if (cnt_q == LAST_BLNK) begin
            state_d = SHOW;
            an_d    = mask_q ? '1 : ~(N_DIGITS'(1) << digit_idx);
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        SHOW: begin
          // Anodes drop on the same edge the new segments load, so a lit
          // digit never sees its neighbour's pattern.
          if (scan_tick) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = nidx;
            an_d    = '1;
            seg_d   = hex7(digits[4*int'(nidx) +: 4]);
            dpn_d   = ~dp[nidx];
            mask_d  = blank_mask[nidx];
            fd_d    = (digit_idx == LAST_IDX);
          end
        end
        default: begin
          state_d = IDLE;
          an_d    = '1;
          seg_d   = 7'h7F;
          dpn_d   = 1'b1;
          idx_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb/tb_display_scan_mux.sv - self-checking bench for display_scan_mux

module tb_display_scan_mux;

  logic        clk;
  logic        rst_n;
  logic        scan_clk;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int cur   = 0;

  typedef struct {
    logic [3:0] val;
    logic       dpv;
    logic [6:0] seg_exp;
    logic       dpn_exp;
  } dec_vec_t;

  dec_vec_t vecs [16];

  display_scan_mux #(.N_DIGITS(4), .BLANK_CYCLES(16), .IDX_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_clk   (scan_clk),
    .en         (en),
    .digits     (digits),
    .dp         (dp),
    .blank_mask (blank_mask),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] exp, input int budget, input string nm);
    int i;
    i = 0;
    while (an !== exp && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(nm, an, exp);
  endtask

  task automatic wait_idx(input logic [1:0] exp, input int budget, input string nm);
    int i;
    i = 0;
    while (digit_idx !== exp && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(nm, digit_idx, exp);
  endtask

  task automatic scan_rise();
    scan_clk = 1'b0;
    repeat (4) @(negedge clk);
    scan_clk = 1'b1;
  endtask

  task automatic advance(input logic [1:0] exp_idx, input logic [3:0] exp_an,
                         input logic [6:0] exp_seg, input string nm);
    scan_rise();
    wait_idx(exp_idx, 8, {nm, "_idx"});
    wait_an(exp_an, 24, {nm, "_an"});
    chk({nm, "_seg"}, seg, exp_seg);
  endtask

  initial begin
    int n;
    int fdc;
    logic [1:0] idx_at_fd;
    logic lit;

    vecs[0]  = '{4'h0, 1'b0, 7'h40, 1'b1};
    vecs[1]  = '{4'h1, 1'b1, 7'h79, 1'b0};
    vecs[2]  = '{4'h2, 1'b0, 7'h24, 1'b1};
    vecs[3]  = '{4'h3, 1'b1, 7'h30, 1'b0};
    vecs[4]  = '{4'h4, 1'b0, 7'h19, 1'b1};
    vecs[5]  = '{4'h5, 1'b0, 7'h12, 1'b1};
    vecs[6]  = '{4'h6, 1'b1, 7'h02, 1'b0};
    vecs[7]  = '{4'h7, 1'b0, 7'h78, 1'b1};
    vecs[8]  = '{4'h8, 1'b1, 7'h00, 1'b0};
    vecs[9]  = '{4'h9, 1'b0, 7'h10, 1'b1};
    vecs[10] = '{4'hA, 1'b0, 7'h08, 1'b1};
    vecs[11] = '{4'hB, 1'b1, 7'h03, 1'b0};
    vecs[12] = '{4'hC, 1'b0, 7'h46, 1'b1};
    vecs[13] = '{4'hD, 1'b0, 7'h21, 1'b1};
    vecs[14] = '{4'hE, 1'b1, 7'h06, 1'b0};
    vecs[15] = '{4'hF, 1'b0, 7'h0E, 1'b1};

    rst_n      = 1'b0;
    scan_clk   = 1'b0;
    en         = 1'b0;
    digits     = 16'h4321;
    dp         = 4'b0000;
    blank_mask = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dpn", dp_n, 1'b1);
    chk("rst_idx", digit_idx, 2'd0);
    chk("rst_fd", frame_done, 1'b0);

    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_an", an, 4'hF);

    // first slot: 16 blank cycles with digit 0 decoded, then anode 0 lit
    en = 1'b1;
    repeat (16) @(negedge clk);
    chk("d0_blank_an", an, 4'hF);
    chk("d0_blank_seg", seg, 7'h79);
    @(negedge clk);
    chk("d0_an", an, 4'hE);
    chk("d0_dpn", dp_n, 1'b1);

    // synchroniser latency from a mid-cycle scan_clk rise
    repeat (5) @(negedge clk);
    scan_clk = 1'b1;
    n = 0;
    while (an !== 4'hF && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("latency", (n >= 2 && n <= 4), 1'b1);
    chk("d1_blank_seg", seg, 7'h24);

    // second rise inside the blank window must not advance again
    scan_clk = 1'b0;
    repeat (3) @(negedge clk);
    scan_clk = 1'b1;
    repeat (5) @(negedge clk);
    wait_an(4'hD, 20, "d1_an");
    chk("d1_seg", seg, 7'h24);
    repeat (30) @(negedge clk);
    chk("no_double_an", an, 4'hD);
    chk("no_double_idx", digit_idx, 2'd1);

    advance(2'd2, 4'hB, 7'h30, "d2");
    advance(2'd3, 4'h7, 7'h19, "d3");

    // wrap 3 -> 0 with a single frame_done pulse
    scan_rise();
    fdc = 0;
    idx_at_fd = 2'd3;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (frame_done) begin
        fdc++;
        idx_at_fd = digit_idx;
      end
    end
    chk("wrap_fd_count", fdc, 1);
    chk("wrap_fd_idx", idx_at_fd, 2'd0);
    chk("wrap_an", an, 4'hE);
    chk("wrap_seg", seg, 7'h79);

    // mid-slot input changes are held off until the next snapshot
    advance(2'd1, 4'hD, 7'h24, "s1");
    digits     = 16'h43F1;
    blank_mask = 4'b0100;
    repeat (5) @(negedge clk);
    chk("snap_hold_seg", seg, 7'h24);
    chk("snap_hold_an", an, 4'hD);

    scan_rise();
    wait_idx(2'd2, 8, "mask_idx");
    lit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (an !== 4'hF) lit = 1'b1;
    end
    chk("mask_never_lit", lit, 1'b0);
    advance(2'd3, 4'h7, 7'h19, "m3");
    advance(2'd0, 4'hE, 7'h79, "m0");
    advance(2'd1, 4'hD, 7'h0E, "snap_new");
    blank_mask = 4'b0000;

    // decoder and decimal point table
    cur = 1;
    for (int v = 0; v < 16; v++) begin
      digits = {4{vecs[v].val}};
      dp     = {4{vecs[v].dpv}};
      cur    = (cur + 1) % 4;
      advance(2'(cur), ~(4'b0001 << cur), vecs[v].seg_exp, $sformatf("dec%0h", vecs[v].val));
      chk($sformatf("dec%0h_dpn", vecs[v].val), dp_n, vecs[v].dpn_exp);
    end

    // drop en while digit 2 is lit
    digits = 16'h4321;
    dp     = 4'b0000;
    while (cur != 2) begin
      cur = (cur + 1) % 4;
      advance(2'(cur), ~(4'b0001 << cur), 7'h7F ^ 7'h7F ^ seg_of(cur), $sformatf("pre_en%0d", cur));
    end
    en = 1'b0;
    @(negedge clk);
    chk("dis_an", an, 4'hF);
    chk("dis_seg", seg, 7'h7F);
    chk("dis_idx", digit_idx, 2'd0);
    chk("dis_dpn", dp_n, 1'b1);
    fdc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_done) fdc++;
    end
    chk("dis_no_fd", fdc, 0);

    en = 1'b1;
    repeat (16) @(negedge clk);
    chk("reen_blank_an", an, 4'hF);
    @(negedge clk);
    chk("reen_an", an, 4'hE);
    chk("reen_seg", seg, 7'h79);

    // async reset in the middle of a lit slot
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", an, 4'hF);
    chk("arst_seg", seg, 7'h7F);
    chk("arst_idx", digit_idx, 2'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", an, 4'hF);
    en = 1'b1;
    repeat (16) @(negedge clk);
    chk("post_rst_blank", an, 4'hF);
    @(negedge clk);
    chk("post_rst_an", an, 4'hE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'h79;
      1: seg_of = 7'h24;
      2: seg_of = 7'h30;
      default: seg_of = 7'h19;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Multiplexed 7-segment display driver. Directly downstream of the clock divider; consumes its ~2 kHz scan output as the digit-advance rate.
- Runs in the 50 MHz `clk` domain. Synchronises and edge-detects the divided scan clock, then cycles one-hot active-low anodes across `N_DIGITS` digits.
- Inserts a blanking gap between digits to prevent ghosting.
- Decodes each digit's 4-bit hex value to active-low segments.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (2..8).
- BLANK_CYCLES, 16, `clk` cycles with all anodes off between digit slots (1..255).
- IDX_W, 2, width of `digit_idx`; must satisfy 2^IDX_W >= N_DIGITS.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- scan_clk  in  1  divided scan clock (~2 kHz) from the divider; treated as asynchronous.
- en  in  1  display enable.
- digits  in  4*N_DIGITS  hex value per digit; digit i is digits[4i+3:4i].
- dp  in  N_DIGITS  decimal point per digit, active-high.
- blank_mask  in  N_DIGITS  1 = digit i never lit.
- an  out  N_DIGITS  anode enables, active-low, one-hot-low or all-high.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- digit_idx  out  IDX_W  index of the current slot.
- frame_done  out  1  one-cycle pulse on wrap from last digit to 0.

Behaviour:
- Reset (async assert, sync release): an = all 1, seg = 7'h7F, dp_n = 1, digit_idx = 0, frame_done = 0, FSM = IDLE, sync/edge registers = 0, blank counter = 0.
- Scan input path:
  - 2-FF synchroniser followed by one delay register.
  - scan_tick = sync2 & ~sync3, a one-cycle pulse.
  - Timing: scan_clk rises before edge k → scan_tick is high during cycle k+1..k+2 → FSM acts on edge k+2.
  - A scan_clk falling edge produces no tick.
- FSM states:
  - IDLE:
    - Outputs: an all 1, seg 7'h7F, dp_n 1, digit_idx 0.
    - en=1 → BLANK. On the transition edge: snapshot digits[3:0], dp[0], blank_mask[0] into slot registers; blank counter = 0.
  - BLANK:
    - Outputs: an all 1; seg/dp_n already show the decoded snapshot.
    - Counter increments each cycle; at counter = BLANK_CYCLES-1 → SHOW.
    - scan_tick during BLANK is ignored (dropped, not queued).
  - SHOW:
    - Outputs: an[digit_idx] = 0 unless the snapshotted mask bit is set (then all 1); seg/dp_n hold the snapshot.
    - On scan_tick → BLANK. On that edge: digit_idx = (digit_idx == N_DIGITS-1) ? 0 : digit_idx+1; snapshot the new slot's digit/dp/mask; counter = 0.
    - If the wrap occurs, frame_done = 1 for exactly that following cycle.
- en=0 in any state:
  - Next edge → IDLE; digit_idx = 0; all outputs off.
  - A pending frame_done is not generated.
  - Resuming always starts at digit 0.
- Snapshot rule: changes on `digits`/`dp`/`blank_mask` mid-slot are not visible until the next slot's snapshot.
- Decoder (active-low {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)
  - dp_n = ~dp_snapshot.
- Invariants:
  - At most one `an` bit low at any cycle.
  - `an` is never low in the same cycle that seg/dp_n change.
  - All outputs are registered; no combinational path from inputs to `an`/`seg`.

Test Plan:
- Reset then en=1, digits=16'h4321, scan_clk toggling every 25 000 clk → an=1110 with seg=79 after 16 blank cycles. Then each scan_clk rise: an all 1 for 16 cycles, then 1101/24, 1011/30, 0111/19.
- Continue past digit 3 → digit_idx 3→0, frame_done high exactly 1 cycle, an returns to 1110.
- Latency: scan_clk rises mid-cycle before edge k → an goes all-high on edge k+2 (±1 for metastability margin); two scan_clk rises inside one BLANK window → second ignored, no double advance.
- digits[7:4] changed from 2 to F during digit-1 SHOW → seg stays 24 until the next frame's digit-1 slot, which shows 0E. blank_mask=4'b0100 → an never 1011; slot timing is unchanged.
- en dropped during digit-2 SHOW → next edge: an=1111, seg=7F, digit_idx=0, no frame_done. Re-enable → restarts at digit 0 after 16 blank cycles.
- rst_n asserted asynchronously mid-SHOW → outputs reach reset values before the next clk edge. After release, FSM sits in IDLE until en is seen high.
